// File: rtl/ex_mem_pkg.sv
// Shared widths and constants for the EX/MEM pipeline register.
package ex_mem_pkg;

  localparam int RegDataBus   = 32;
  localparam int RegAddrBus   = 5;
  localparam int StallBus     = 6;
  localparam int DoubleRegBus = 64;
  localparam int CntBus       = 2;

  localparam logic                    RstEnable    = 1'b1;
  localparam logic                    WriteEnable  = 1'b1;
  localparam logic                    WriteDisable = 1'b0;
  localparam logic [RegDataBus-1:0]   ZeroWord     = '0;
  localparam logic [RegAddrBus-1:0]   NOPRegAddr   = '0;
  localparam logic [DoubleRegBus-1:0] ZeroDouble   = '0;
  localparam logic [CntBus-1:0]       ZeroCnt      = '0;

  // Bit positions in the stall vector for the two stages this register sits between.
  localparam int StallEx  = 3;
  localparam int StallMem = 4;

endpackage

// File: rtl/ex_mem.sv
// EX/MEM pipeline register: write-back and HI/LO fields to memory stage,
// plus the madd/msub partial product and counter fed back to execute.
module ex_mem
  import ex_mem_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [StallBus-1:0]     stall,
  input  logic                    flush,
  input  logic [RegAddrBus-1:0]   ex_wd,
  input  logic                    ex_wreg,
  input  logic [RegDataBus-1:0]   ex_wdata,
  input  logic                    ex_whilo,
  input  logic [RegDataBus-1:0]   ex_hi,
  input  logic [RegDataBus-1:0]   ex_lo,
  input  logic [DoubleRegBus-1:0] hilo_i,
  input  logic [CntBus-1:0]       cnt_i,
  output logic [RegAddrBus-1:0]   mem_wd,
  output logic                    mem_wreg,
  output logic [RegDataBus-1:0]   mem_wdata,
  output logic                    mem_whilo,
  output logic [RegDataBus-1:0]   mem_hi,
  output logic [RegDataBus-1:0]   mem_lo,
  output logic [DoubleRegBus-1:0] hilo_o,
  output logic [CntBus-1:0]       cnt_o
);

  logic ex_stalled, bubble;

  assign ex_stalled = stall[StallEx];
  // Execute held while memory runs: memory must see a NOP, not a repeat.
  assign bubble     = stall[StallEx] & ~stall[StallMem];

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      mem_wd    <= NOPRegAddr;
      mem_wreg  <= WriteDisable;
      mem_wdata <= ZeroWord;
      mem_whilo <= WriteDisable;
      mem_hi    <= ZeroWord;
      mem_lo    <= ZeroWord;
    end else if (flush || bubble) begin
      mem_wd    <= NOPRegAddr;
      mem_wreg  <= WriteDisable;
      mem_wdata <= ZeroWord;
      mem_whilo <= WriteDisable;
      mem_hi    <= ZeroWord;
      mem_lo    <= ZeroWord;
    end else if (!ex_stalled) begin
      mem_wd    <= ex_wd;
      mem_wreg  <= ex_wreg;
      mem_wdata <= ex_wdata;
      mem_whilo <= ex_whilo;
      mem_hi    <= ex_hi;
      mem_lo    <= ex_lo;
    end
  end

  // Partial product survives only while execute is stalled; any advance ends the op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      hilo_o <= ZeroDouble;
      cnt_o  <= ZeroCnt;
    end else if (flush) begin
      hilo_o <= ZeroDouble;
      cnt_o  <= ZeroCnt;
    end else if (ex_stalled) begin
      hilo_o <= hilo_i;
      cnt_o  <= cnt_i;
    end else begin
      hilo_o <= ZeroDouble;
      cnt_o  <= ZeroCnt;
    end
  end

endmodule

// File: tb/tb_ex_mem.sv
// Bench for ex_mem: case-rule model checked every cycle plus directed literal checks.
module tb_ex_mem;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic        ex_whilo;
  logic [31:0] ex_hi, ex_lo;
  logic [63:0] hilo_i;
  logic [1:0]  cnt_i;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        mem_whilo;
  logic [31:0] mem_hi, mem_lo;
  logic [63:0] hilo_o;
  logic [1:0]  cnt_o;

  int compared   = 0;
  int mismatched = 0;
  bit model_on   = 0;

  ex_mem dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo),
    .hilo_i(hilo_i), .cnt_i(cnt_i),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .hilo_o(hilo_o), .cnt_o(cnt_o)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [63:0] hilo;
    logic [1:0]  cnt;
  } st_t;

  st_t exp_st;

  // Next visible state from the four priority cases, acting on whole records.
  function automatic st_t next_state(st_t cur);
    st_t n;
    st_t ex_rec;
    ex_rec = '{ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo, 64'd0, 2'd0};
    if (flush)                       n = '0;
    else if (!stall[3])              n = ex_rec;
    else begin
      n = stall[4] ? cur : '0;
      n.hilo = hilo_i;
      n.cnt  = cnt_i;
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) exp_st <= '0;
    else     exp_st <= next_state(exp_st);
  end

  always @(posedge clk)
    if (!rst && !stall[3] && stall[4])
      $error("illegal stall pattern %b", stall);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (model_on) begin
      chk("m_wd",    64'(mem_wd),    64'(exp_st.wd));
      chk("m_wreg",  64'(mem_wreg),  64'(exp_st.wreg));
      chk("m_wdata", 64'(mem_wdata), 64'(exp_st.wdata));
      chk("m_whilo", 64'(mem_whilo), 64'(exp_st.whilo));
      chk("m_hi",    64'(mem_hi),    64'(exp_st.hi));
      chk("m_lo",    64'(mem_lo),    64'(exp_st.lo));
      chk("m_hilo",  hilo_o,         exp_st.hilo);
      chk("m_cnt",   64'(cnt_o),     64'(exp_st.cnt));
    end
  end

  // Clock once; returns 2 time units after the edge with outputs settled.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_wd"},    64'(mem_wd), 64'd0);
    chk({name, "_wreg"},  64'(mem_wreg), 64'd0);
    chk({name, "_wdata"}, 64'(mem_wdata), 64'd0);
    chk({name, "_whilo"}, 64'(mem_whilo), 64'd0);
    chk({name, "_hi"},    64'(mem_hi), 64'd0);
    chk({name, "_lo"},    64'(mem_lo), 64'd0);
    chk({name, "_hilo"},  hilo_o, 64'd0);
    chk({name, "_cnt"},   64'(cnt_o), 64'd0);
  endtask

  initial begin
    rst = 1; stall = 0; flush = 0;
    ex_wd = 0; ex_wreg = 0; ex_wdata = 0; ex_whilo = 0; ex_hi = 0; ex_lo = 0;
    hilo_i = 0; cnt_i = 0;
    #12;
    chk_all_zero("init");
    rst = 0;
    model_on = 1;

    // Reset: load nonzero state, then pulse rst between edges.
    ex_wd = 5'd31; ex_wreg = 1; ex_wdata = 32'hFFFF_0001; ex_whilo = 1;
    ex_hi = 32'h1111_1111; ex_lo = 32'h2222_2222; hilo_i = 64'h55; cnt_i = 2'd3;
    tick();
    chk("pre_rst_wdata", 64'(mem_wdata), 64'hFFFF_0001);
    #1 rst = 1;
    #1 chk_all_zero("rst");
    #1 rst = 0;

    // Advance
    stall = 0; ex_wd = 5; ex_wreg = 1; ex_wdata = 32'h1234_5678; ex_whilo = 1;
    ex_hi = 32'hA; ex_lo = 32'hB; hilo_i = 64'h77; cnt_i = 2'd2;
    tick();
    chk("adv_wd", 64'(mem_wd), 64'd5);
    chk("adv_wreg", 64'(mem_wreg), 64'd1);
    chk("adv_wdata", 64'(mem_wdata), 64'h1234_5678);
    chk("adv_whilo", 64'(mem_whilo), 64'd1);
    chk("adv_hi", 64'(mem_hi), 64'hA);
    chk("adv_lo", 64'(mem_lo), 64'hB);
    chk("adv_hilo", hilo_o, 64'd0);
    chk("adv_cnt", 64'(cnt_o), 64'd0);

    // Bubble, then release
    stall = 6'b001111; hilo_i = 64'h0000_0001_FFFF_FFFE; cnt_i = 1;
    ex_wdata = 32'h0BAD_F00D;
    tick();
    chk("bub_wreg", 64'(mem_wreg), 64'd0);
    chk("bub_wdata", 64'(mem_wdata), 64'd0);
    chk("bub_hilo", hilo_o, 64'h0000_0001_FFFF_FFFE);
    chk("bub_cnt", 64'(cnt_o), 64'd1);
    stall = 0; cnt_i = 2; ex_wdata = 32'hCAFE_0002;
    tick();
    chk("rel_wdata", 64'(mem_wdata), 64'hCAFE_0002);
    chk("rel_wreg", 64'(mem_wreg), 64'd1);
    chk("rel_hilo", hilo_o, 64'd0);
    chk("rel_cnt", 64'(cnt_o), 64'd0);

    // Hold
    ex_wdata = 32'hDEAD_BEEF;
    tick();
    stall = 6'b011111;
    for (int i = 0; i < 3; i++) begin
      ex_wdata = 32'h100 + 32'(i);
      hilo_i = 64'(i + 9); cnt_i = 2'(i);
      tick();
      chk("hold_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
      chk("hold_hilo", hilo_o, 64'(i + 9));
    end

    // Flush during a madd bubble wins over stall
    stall = 6'b001111; hilo_i = 64'hABCD; cnt_i = 1;
    tick();
    chk("pre_fl_cnt", 64'(cnt_o), 64'd1);
    flush = 1; hilo_i = 64'h1234; cnt_i = 1;
    tick();
    chk_all_zero("flush");
    flush = 0; stall = 0;

    // Back-to-back random traffic, checked by the model every cycle.
    for (int i = 0; i < 100; i++) begin
      ex_wd = 5'($urandom); ex_wreg = 1'($urandom); ex_wdata = $urandom;
      ex_whilo = 1'($urandom); ex_hi = $urandom; ex_lo = $urandom;
      hilo_i = {$urandom, $urandom}; cnt_i = 2'($urandom);
      tick();
    end

    // Mixed legal stall/flush patterns.
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: stall = 6'b000000;
        1: stall = 6'b001111;
        2: stall = 6'b011111;
        default: stall = 6'b111111;
      endcase
      flush = ($urandom_range(0, 9) == 0);
      ex_wd = 5'($urandom); ex_wreg = 1'($urandom); ex_wdata = $urandom;
      ex_whilo = 1'($urandom); ex_hi = $urandom; ex_lo = $urandom;
      hilo_i = {$urandom, $urandom}; cnt_i = 2'($urandom);
      tick();
    end
    flush = 0; stall = 0;
    @(negedge clk);
    model_on = 0;
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ex_mem.md
# ex_mem

Pipeline register between the execute stage and the memory-access stage of the five-stage MIPS core. Captures the execute stage's write-back results (destination register, write enable, data) and HI/LO results on each rising clock edge and presents them to the memory stage. Honours the central stall vector and a flush request. Also holds the 64-bit partial product and cycle counter that multi-cycle `madd`/`msub` operations feed back into the execute stage while it is stalled.

## Interface
- Parameters: none. Widths come from the shared defines: `RegDataBus` is 32 bits, `RegAddrBus` is 5 bits, `StallBus` is 6 bits, `DoubleRegBus` is 64 bits.
- `clk` input 1 — single clock; all state updates on the rising edge.
- `rst` input 1 — reset; asynchronous, active-high.
- `stall` input 6 — stall vector: [0] pc, [1] if, [2] id, [3] ex, [4] mem, [5] wb.
- `flush` input 1 — synchronous pipeline flush (exception or eret).
- `ex_wd` input 5 — destination register address from execute.
- `ex_wreg` input 1 — register write enable from execute.
- `ex_wdata` input 32 — result data from execute.
- `ex_whilo` input 1 — HI/LO write enable from execute.
- `ex_hi`, `ex_lo` input 32 each — HI/LO results from execute.
- `hilo_i` input 64 — partial product produced by execute this cycle.
- `cnt_i` input 2 — multi-cycle counter produced by execute this cycle.
- `mem_wd` output 5, `mem_wreg` output 1, `mem_wdata` output 32 — registered write-back fields to the memory stage.
- `mem_whilo` output 1, `mem_hi` output 32, `mem_lo` output 32 — registered HI/LO fields to the memory stage.
- `hilo_o` output 64, `cnt_o` output 2 — registered partial product and counter, fed back to execute.

## Operation
- All outputs are registers. Reset value of every output is zero: `mem_wd`=`NOPRegAddr` (0), every enable 0, all data 0, `hilo_o`=0, `cnt_o`=0.
- On each rising edge, exactly one of the following cases applies, in this priority order:
  1. **Flush** (`flush`=1): all outputs are cleared to their reset values. Flush overrides any stall.
  2. **Bubble** (`stall[3]`=1 and `stall[4]`=0): all `mem_*` outputs are cleared, which inserts a NOP into the memory stage. `hilo_o`<=`hilo_i` and `cnt_o`<=`cnt_i`, so execute accumulates across the stall.
  3. **Advance** (`stall[3]`=0): every `mem_*` output takes its `ex_*` counterpart. `hilo_o` and `cnt_o` are cleared, because the multi-cycle operation has completed or none is in progress.
  4. **Hold** (`stall[3]`=1 and `stall[4]`=1): all `mem_*` outputs keep their values. `hilo_o`<=`hilo_i` and `cnt_o`<=`cnt_i`.
- The pair `stall[3]`=0 with `stall[4]`=1 is illegal: the stall controller never stalls a later stage without stalling the earlier ones. If it occurs, the block applies case 3 (advance). A bench assertion flags it.
- `cnt` protocol, owned by execute:
  - 0 = first cycle of `madd`/`msub`; execute requests a stall and sets `cnt_i`=1.
  - 1 = second cycle; execute uses `hilo_o`, releases the stall and sets `cnt_i`=2.
  - The block never modifies `cnt`; it only registers or clears it per the cases above.
- No arithmetic is performed; all values are passed through at full width.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
- Asserting `rst` clears all outputs immediately, without waiting for a clock edge. Deasserting `rst` takes effect at the next rising edge. Reset in the middle of a `madd` abandons the partial product (`hilo_o`=0, `cnt_o`=0).
- Flush in the middle of a `madd` likewise clears `hilo_o` and `cnt_o` on that edge.
- There are no combinational paths from inputs to outputs.

## Structure
- The shared defines header supplies `RstEnable`, `ZeroWord`, `NOPRegAddr`, `StallBus`, `DoubleRegBus`, `RegAddrBus`, `RegDataBus`, `WriteEnable` and `WriteDisable`. No new constants are added outside it.
- Single flat module with no sub-modules. The write-back group and the HI/LO group may each be written as a separate always block; both blocks follow the same priority order.

## Test plan
- **Reset:** drive all inputs to nonzero values and pulse `rst` between clock edges → all outputs read 0 while `rst` is high, before any edge.
- **Advance:** `stall`=0, `ex_wd`=5, `ex_wreg`=1, `ex_wdata`=0x1234_5678, `ex_whilo`=1, `ex_hi`=0xA, `ex_lo`=0xB → after one edge, `mem_*` equal these values and `hilo_o`=0, `cnt_o`=0.
- **Bubble:** `stall`=6'b001111, `hilo_i`=0x0000_0001_FFFF_FFFE, `cnt_i`=1 → `mem_wreg`=0, `mem_wdata`=0, `hilo_o`=0x0000_0001_FFFF_FFFE, `cnt_o`=1. The next cycle with `stall`=0 → `mem_*` take the `ex_*` values and `hilo_o`=0.
- **Hold:** load `mem_wdata`=0xDEAD_BEEF, then apply `stall`=6'b011111 for 3 cycles while `ex_wdata` changes every cycle → `mem_wdata` stays 0xDEAD_BEEF for all 3 cycles.
- **Flush priority:** `flush`=1 together with `stall`=6'b001111 and `cnt_i`=1 → every output is 0 after the edge.
- **Back-to-back:** random `ex_*` values every cycle with `stall`=0 for 100 cycles → `mem_*` always equal the previous cycle's `ex_*` (scoreboard check).
